// File: rtl/cache_sram_pkg.sv
// Shared widths and the response entry type for the cache data SRAM port controller.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package cache_sram_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 256;
  localparam int DEFAULT_ID_W   = 4;

  // One returned read: the tag travels with its data word.
  typedef struct packed {
    logic [DEFAULT_ID_W-1:0]   id;
    logic [DEFAULT_DATA_W-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/cache_sram_rsp_fifo.sv
// Generic DEPTH-entry synchronous FIFO of rsp_entry_t with an occupancy count.
// Latency: an entry pushed at a clock edge is visible on head in the next cycle.
// Backpressure: none internally; the producer's credit check keeps it from overflowing.
module cache_sram_rsp_fifo
  import cache_sram_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  rsp_entry_t       push_entry,
  input  logic             pop,
  output rsp_entry_t       head,
  output logic [CNT_W-1:0] count
);

  rsp_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ignore pops on empty and pushes on full (a pop in the same cycle makes room).
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  end

  // Circular buffer storage, pointers and occupancy; reset clears the contents too.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cache_sram_port_ctrl.sv
// Arbitrates fill writes against lookup reads onto one 1RW SRAM and returns read data in issue order.
// Latency: write commits in the grant cycle; read response 2 cycles after accept (1 with CACHE_SRAM_RSP_BYPASS_EN).
// Backpressure: reads need a free response credit (inflight + FIFO count < RSP_DEPTH); writes win unless a read starves.
module cache_sram_port_ctrl
  import cache_sram_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int ID_W         = DEFAULT_ID_W,
  parameter int RSP_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ID_W-1:0]   rd_id,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  output logic              sram_valid,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W    = $clog2(RSP_DEPTH + 1);
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

  logic                inflight;
  logic [ID_W-1:0]     held_id;
  logic [STREAK_W-1:0] streak;
  logic [CNT_W-1:0]    fifo_count;
  logic                rd_eligible;
  logic                rd_grant;
  logic                wr_grant;
  logic                fifo_push;
  logic                fifo_pop;
  rsp_entry_t          fifo_in;
  rsp_entry_t          fifo_head;

  // Grant: a read needs a credit counted against the start-of-cycle FIFO count; writes win unless starved.
  always_comb begin
    rd_eligible = !reset && rd_valid &&
                  ((CNT_W'(inflight) + fifo_count) < CNT_W'(RSP_DEPTH));
    rd_grant    = rd_eligible && (!wr_valid || (streak == STREAK_W'(STARVE_LIMIT)));
    wr_grant    = !reset && wr_valid && !rd_grant;
  end

  assign rd_ready   = rd_grant;
  assign wr_ready   = wr_grant;
  assign sram_valid = rd_grant || wr_grant;
  assign sram_write = wr_grant;
  assign sram_addr  = wr_grant ? wr_addr : rd_addr;
  assign sram_wdata = wr_data;

  // Count writes that bypass a waiting read; saturate at the limit so the read is forced next.
  always_ff @(posedge clock) begin
    if (reset || rd_grant || !rd_eligible) begin
      streak <= '0;
    end else if (wr_grant && (streak != STREAK_W'(STARVE_LIMIT))) begin
      streak <= streak + 1'b1;
    end
  end

  // Remember that the SRAM output will carry read data next cycle, and whose it is.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= 1'b0;
      held_id  <= '0;
    end else begin
      inflight <= rd_grant;
      if (rd_grant) held_id <= rd_id;
    end
  end

  // SRAM output is captured in the cycle after issue, before a same-cycle write can change it.
  assign fifo_in = '{id: held_id, data: sram_rdata};

`ifdef CACHE_SRAM_RSP_BYPASS_EN
  logic fifo_empty;

  // Present SRAM data directly when nothing is queued ahead of it; only queue it if not taken.
  always_comb begin
    fifo_empty = (fifo_count == '0);
    fifo_pop   = !fifo_empty && rsp_ready;
    fifo_push  = inflight && !(fifo_empty && rsp_ready);
    if (fifo_empty) begin
      rsp_valid = inflight && !reset;
      rsp_data  = sram_rdata;
      rsp_id    = held_id;
    end else begin
      rsp_valid = !reset;
      rsp_data  = fifo_head.data;
      rsp_id    = fifo_head.id;
    end
  end
`else
  assign fifo_push = inflight;
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign rsp_valid = (fifo_count != '0);
  assign rsp_data  = fifo_head.data;
  assign rsp_id    = fifo_head.id;
`endif

  cache_sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

endmodule
